cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/arbiter_types.sv | 16 +
 rtl/cache_arbiter.sv | 92 +++++++++
 tb/tb_cache_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arbiter_types.sv
// Shared types for the I/D cache memory-port arbiter: FSM states and grant side.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache onto one memory port, alternating on ties.
// The address, write data and direction are latched at grant so that the memory side never follows the requestor inputs.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state, state_next;
  grant_t            last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              load_i, load_d, d_pend;

  assign d_pend = d_read | d_write;

  always_comb begin
    state_next = state;
    load_i     = 1'b0;
    load_d     = 1'b0;
    case (state)
      // D wins when I is idle, or on a tie when I was served last.
      IDLE: begin
        if (d_pend && (!i_read || last_grant == GRANT_I)) begin
          state_next = SERVE_D;
          load_d     = 1'b1;
        end else if (i_read) begin
          state_next = SERVE_I;
          load_i     = 1'b1;
        end
      end
      SERVE_I, SERVE_D: if (mem_resp) state_next = RELEASE;
      RELEASE:          state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (load_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        write_q <= d_write;
      end else if (load_i) begin
        addr_q  <= i_addr;
        wdata_q <= '0;
        write_q <= 1'b0;
      end
      if (mem_resp && (state == SERVE_I || state == SERVE_D))
        last_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
    end
  end

  // A resp coincident with reset belongs to an abandoned transaction.
  assign mem_read  = (state == SERVE_I) || (state == SERVE_D && !write_q);
  assign mem_write = (state == SERVE_D) && write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_resp    = (state == SERVE_I) && mem_resp && !reset;
  assign d_resp    = (state == SERVE_D) && mem_resp && !reset;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Random traffic from both caches plus a random-latency memory, checked cycle by cycle
// against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read, d_read, d_write, mem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_resp, d_resp, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: busy = a transaction owns the port, cool = the one dead cycle after completion.
  bit                busy, cool, owner_d, last_d, lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_data;
  int                mem_wait;
  bit                e_ir, e_dr, prev_ir, prev_dr;
  int                grants_d, grants_i, stray;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Applies the request/response rules seen at the edge just passed.
  task automatic model_edge(output bit granted);
    granted = 0;
    if (reset) begin
      busy = 0; cool = 0; last_d = 0; lat_wr = 0; lat_addr = '0; lat_data = '0;
    end else if (busy) begin
      if (mem_resp) begin busy = 0; cool = 1; last_d = owner_d; end
    end else if (cool) begin
      cool = 0;
    end else begin
      bit dp;
      dp = d_read | d_write;
      if (dp && !(i_read && last_d)) begin
        busy = 1; owner_d = 1; lat_addr = d_addr; lat_data = d_wdata; lat_wr = d_write;
        granted = 1; grants_d++;
      end else if (i_read) begin
        busy = 1; owner_d = 0; lat_addr = i_addr; lat_wr = 0;
        granted = 1; grants_i++;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    bit emr, emw;
    emr  = busy && (!owner_d || !lat_wr);
    emw  = busy && owner_d && lat_wr;
    e_ir = busy && !owner_d && mem_resp && !reset;
    e_dr = busy && owner_d && mem_resp && !reset;
    chk({ph, "_mem_read"},  LINE_W'(mem_read),  LINE_W'(emr));
    chk({ph, "_mem_write"}, LINE_W'(mem_write), LINE_W'(emw));
    chk({ph, "_i_resp"},    LINE_W'(i_resp),    LINE_W'(e_ir));
    chk({ph, "_d_resp"},    LINE_W'(d_resp),    LINE_W'(e_dr));
    if (emr || emw) chk({ph, "_mem_addr"}, LINE_W'(mem_addr), LINE_W'(lat_addr));
    if (emw)        chk({ph, "_mem_wdata"}, mem_wdata, lat_data);
    if (e_ir)       chk({ph, "_i_rdata"}, i_rdata, mem_rdata);
    if (e_dr)       chk({ph, "_d_rdata"}, d_rdata, mem_rdata);
  endtask

  initial begin
    bit g;
    reset = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    busy = 0; cool = 0; owner_d = 0; last_d = 0; lat_wr = 0; lat_addr = '0; lat_data = '0;
    mem_wait = 0; prev_ir = 0; prev_dr = 0; grants_d = 0; grants_i = 0; stray = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_mem_addr", LINE_W'(mem_addr), '0);
    chk("reset_mem_wdata", mem_wdata, '0);

    // Opening tie right after reset: D must go first.
    reset = 0;
    i_read = 1; i_addr = 32'h0000_0060;
    d_read = 1; d_addr = 32'h0000_1000;
    #1;
    check_outputs("tie0");

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      model_edge(g);
      if (cyc == 0) chk("tie_first_is_d", LINE_W'(owner_d), LINE_W'(1));
      if (g) mem_wait = $urandom_range(0, 3);

      reset = ($urandom_range(0, 199) == 0);
      mem_rdata = rand_line();
      mem_resp = 0;
      if (busy) begin
        if (mem_wait == 0) mem_resp = 1; else mem_wait--;
      end else if ($urandom_range(0, 9) == 0) begin
        mem_resp = 1; stray++;
      end

      // I-cache requestor
      if (prev_ir) begin
        i_read = $urandom_range(0, 1);
        if (i_read) i_addr = {$urandom_range(0, 32'hFFFF), 5'b0};
      end else if (i_read) begin
        if (!(busy && !owner_d) && $urandom_range(0, 19) == 0) i_read = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_read = 1; i_addr = {$urandom_range(0, 32'hFFFF), 5'b0};
      end
      // D-cache requestor
      if (prev_dr || (!d_read && !d_write && $urandom_range(0, 2) == 0)) begin
        d_read = 0; d_write = 0;
        if (!prev_dr || $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) d_write = 1; else d_read = 1;
          d_addr = {$urandom_range(0, 32'hFFFF), 5'b0};
          d_wdata = rand_line();
        end
      end else if ((d_read || d_write) && !(busy && owner_d) && $urandom_range(0, 19) == 0) begin
        d_read = 0; d_write = 0;
      end
      if (reset) begin i_read = 0; d_read = 0; d_write = 0; end

      #1;
      check_outputs("run");
      prev_ir = e_ir;
      prev_dr = e_dr;
    end

    chk("saw_both_grants", LINE_W'((grants_d > 10) && (grants_i > 10)), LINE_W'(1));
    chk("saw_stray_resp", LINE_W'(stray > 0), LINE_W'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
